// File: rtl/handshake_skid.sv
// handshake_skid
//   Two-entry valid/ready skid buffer. Both the forward path (valid/data) and
//   the backward path (ready) come straight from flops, so downstream ready
//   has no combinational route to upstream ready. Sustains one word per cycle.
//
// Optional feature macro: HS_SKID_CNT_EN
//   When defined, adds xfer_cnt_o, a 16-bit wrapping count of downstream
//   transfers. When undefined, the port and counter do not exist.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   d_valid_i   in   upstream word valid
//   d_data_i    in   upstream word [DW-1:0]
//   d_ready_o   out  buffer can take a word this cycle (registered)
//   s_valid_o   out  buffer presents a word (registered)
//   s_data_o    out  presented word [DW-1:0] (registered)
//   s_ready_i   in   downstream takes the word this cycle
//   xfer_cnt_o  out  downstream transfer count [15:0] (HS_SKID_CNT_EN only)

module handshake_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_valid_i,
  input  logic [DW-1:0] d_data_i,
  output logic          d_ready_o,
  output logic          s_valid_o,
  output logic [DW-1:0] s_data_o,
`ifdef HS_SKID_CNT_EN
  output logic [15:0]   xfer_cnt_o,
`endif
  input  logic          s_ready_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_reg;
  logic          d_ready_reg;
  logic          s_valid_reg;
  logic [DW-1:0] main_reg;
  logic [DW-1:0] skid_reg;

  logic          in_xfer;
  logic          out_xfer;

  // Both handshakes are built from registered outputs, so neither term adds
  // a combinational ready path through this block.
  assign in_xfer  = d_valid_i & d_ready_reg;
  assign out_xfer = s_valid_reg & s_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= EMPTY;
      d_ready_reg <= 1'b0;
      s_valid_reg <= 1'b0;
      main_reg    <= '0;
      skid_reg    <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          // d_ready is 0 only on the first cycle after reset; raise it here.
          d_ready_reg <= 1'b1;
          if (in_xfer) begin
            state_reg   <= BUSY;
            main_reg    <= d_data_i;
            s_valid_reg <= 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && !out_xfer) begin
            // Downstream stalled while a word arrived: park it in the skid
            // and stop accepting until the main word drains.
            state_reg   <= FULL;
            skid_reg    <= d_data_i;
            d_ready_reg <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state_reg   <= EMPTY;
            s_valid_reg <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_reg <= d_data_i;
          end
        end
        FULL: begin
          // No input can occur here since d_ready is low.
          if (out_xfer) begin
            state_reg   <= BUSY;
            main_reg    <= skid_reg;
            d_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= EMPTY;
          d_ready_reg <= 1'b0;
          s_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef HS_SKID_CNT_EN
  logic [15:0] cnt_reg;

  // Reset has priority, so a transfer on a reset edge is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (out_xfer) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign xfer_cnt_o = cnt_reg;
`endif

  assign d_ready_o = d_ready_reg;
  assign s_valid_o = s_valid_reg;
  assign s_data_o  = main_reg;

endmodule

// File: tb/tb_handshake_skid.sv
// tb_handshake_skid
//   Directed checks for handshake_skid: reset, streaming, skid/backpressure,
//   reset while full, random stall with an in-order scoreboard and, when
//   HS_SKID_CNT_EN is defined, the transfer counter including its wrap.
//   Inputs change 1 time unit after each rising edge; outputs are sampled then.

module tb_handshake_skid;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          d_valid;
  logic [DW-1:0] d_data;
  logic          d_ready;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
`ifdef HS_SKID_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  int total;
  int bad;
  logic [15:0] exp_cnt;

  handshake_skid #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_valid_i (d_valid),
    .d_data_i  (d_data),
    .d_ready_o (d_ready),
    .s_valid_o (s_valid),
    .s_data_o  (s_data),
`ifdef HS_SKID_CNT_EN
    .xfer_cnt_o(xfer_cnt),
`endif
    .s_ready_i (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
`ifdef HS_SKID_CNT_EN
    check(tag, 32'(xfer_cnt), 32'(exp_cnt));
`endif
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] held;
    logic [DW-1:0] head;
    logic          dr0;
    logic          stalled;
    int            guard;

    total   = 0;
    bad     = 0;
    exp_cnt = 16'd0;
    rst     = 1'b1;
    d_valid = 1'b1;
    d_data  = 8'hAA;
    s_ready = 1'b0;

    // ---------------- reset ----------------
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_d_ready", 32'(d_ready), 32'd0);
      check("rst_s_data", 32'(s_data), 32'h00);
    end
    check_cnt("rst_cnt");
    rst     = 1'b0;
    d_valid = 1'b0;
    step();
    check("rel_d_ready", 32'(d_ready), 32'd1);
    check("rel_s_valid", 32'(s_valid), 32'd0);
    $display("reset phase done");

    // ---------------- streaming ----------------
    s_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      d_valid = 1'b1;
      d_data  = 8'(i);
      check("str_d_ready", 32'(d_ready), 32'd1);
      step();
      check("str_s_valid", 32'(s_valid), 32'd1);
      check("str_s_data", 32'(s_data), 32'(i));
      $display("stream word %0h", i);
    end
    d_valid = 1'b0;
    step();
    check("str_drain_s_valid", 32'(s_valid), 32'd0);
    exp_cnt = 16'd16;
    check_cnt("str_cnt");

    // ---------------- skid ----------------
    s_ready = 1'b0;
    d_valid = 1'b1;
    d_data  = 8'h11;
    step();
    check("skid_busy_data", 32'(s_data), 32'h11);
    check("skid_busy_d_ready", 32'(d_ready), 32'd1);
    d_data = 8'h22;
    step();
    check("skid_full_d_ready", 32'(d_ready), 32'd0);
    check("skid_full_s_data", 32'(s_data), 32'h11);
    check("skid_full_s_valid", 32'(s_valid), 32'd1);
    d_data = 8'h99;  // must be ignored while d_ready is low
    step();
    check("skid_hold_s_data", 32'(s_data), 32'h11);
    check("skid_hold_d_ready", 32'(d_ready), 32'd0);
    d_valid = 1'b0;
    s_ready = 1'b1;
    step();
    check("skid_out1_s_data", 32'(s_data), 32'h22);
    check("skid_out1_d_ready", 32'(d_ready), 32'd1);
    check("skid_out1_s_valid", 32'(s_valid), 32'd1);
    step();
    check("skid_out2_s_valid", 32'(s_valid), 32'd0);
    exp_cnt = 16'd18;
    check_cnt("skid_cnt");
    $display("skid phase done");

    // ---------------- reset while full ----------------
    s_ready = 1'b0;
    d_valid = 1'b1;
    d_data  = 8'h33;
    step();
    d_data = 8'h44;
    step();
    check("rf_full_d_ready", 32'(d_ready), 32'd0);
    check("rf_full_s_data", 32'(s_data), 32'h33);
    rst     = 1'b1;
    d_valid = 1'b0;
    s_ready = 1'b1;  // an out would happen here if reset did not win
    step();
    check("rf_s_valid", 32'(s_valid), 32'd0);
    check("rf_s_data", 32'(s_data), 32'h00);
    check("rf_d_ready", 32'(d_ready), 32'd0);
    check_cnt("rf_cnt");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rf_after_s_valid", 32'(s_valid), 32'd0);
    end
    check("rf_after_d_ready", 32'(d_ready), 32'd1);
    $display("reset-while-full phase done");

    // ---------------- random stall ----------------
    for (int c = 0; c < 1000; c++) begin
      dr0     = d_ready;
      d_valid = 1'($urandom_range(0, 1));
      d_data  = 8'($urandom);
      s_ready = 1'($urandom_range(0, 1));
      #1;
      check("rnd_no_comb_ready", 32'(d_ready), 32'(dr0));
      if (s_valid && s_ready) begin
        if (q.size() == 0) begin
          check("rnd_underflow", 32'(q.size()), 32'd1);
        end else begin
          head = q.pop_front();
          check("rnd_order", 32'(s_data), 32'(head));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (d_valid && d_ready) q.push_back(d_data);
      stalled = s_valid && !s_ready;
      held    = s_data;
      step();
      if (stalled) begin
        check("rnd_hold_valid", 32'(s_valid), 32'd1);
        check("rnd_hold_data", 32'(s_data), 32'(held));
      end
    end
    d_valid = 1'b0;
    s_ready = 1'b1;
    guard   = 0;
    while (q.size() > 0 && guard < 8) begin
      #1;
      if (s_valid) begin
        head = q.pop_front();
        check("rnd_drain", 32'(s_data), 32'(head));
        exp_cnt = exp_cnt + 16'd1;
      end
      step();
      guard++;
    end
    check("rnd_drain_left", 32'(q.size()), 32'd0);
    check("rnd_empty", 32'(s_valid), 32'd0);
    check_cnt("rnd_cnt");
    $display("random phase done");

`ifdef HS_SKID_CNT_EN
    // ---------------- counter wrap ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("wrap_cnt0", 32'(xfer_cnt), 32'd0);
    d_valid = 1'b1;
    s_ready = 1'b1;
    d_data  = 8'h5A;
    for (int i = 0; i < 65535; i++) step();
    d_valid = 1'b0;
    step();
    check("wrap_cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    step();
    check("wrap_cnt_0", 32'(xfer_cnt), 32'h0000);
    $display("wrap phase done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshake_skid.md
# handshake_skid

Two-entry valid/ready skid buffer for the handshake datapath. It registers the backward (ready) path in addition to the forward (valid/data) path, so there is no combinational path from downstream `s_ready_i` to upstream `d_ready_o`. Sustained throughput is one word per cycle. It is inserted between an upstream producer (`d_` side) and a downstream consumer (`s_` side) wherever ready timing must be cut.

## Interface
- `DW`, default 8: data width in bits.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `d_valid_i`  in  1  upstream has a valid word.
- `d_data_i`  in  DW  upstream data.
- `d_ready_o`  out  1  block accepts a word this cycle; registered.
- `s_valid_o`  out  1  block presents a valid word; registered.
- `s_data_o`  out  DW  output data; registered.
- `s_ready_i`  in  1  downstream accepts a word this cycle.
- `xfer_cnt_o`  out  16  downstream transfer count; present only with `HS_SKID_CNT_EN`.

## Operation
- An input transfer (`in`) occurs when `d_valid_i & d_ready_o`.
- An output transfer (`out`) occurs when `s_valid_o & s_ready_i`.
- Storage:
  - main register: drives `s_data_o`.
  - skid register: holds a second word.
- States:
  - EMPTY: 0 words.
  - BUSY: main full.
  - FULL: main and skid full.
- Outputs by state:
  - `s_valid_o` = 1 in BUSY and FULL.
  - `d_ready_o` = 1 in EMPTY and BUSY.
  - Both are driven from flops, not decoded from `s_ready_i`.
- Transitions:
  - EMPTY: `in` → BUSY, main ← `d_data_i`. Otherwise stay.
  - BUSY, `in & !out` → FULL, skid ← `d_data_i`.
  - BUSY, `!in & out` → EMPTY.
  - BUSY, `in & out` → BUSY, main ← `d_data_i`.
  - BUSY, neither → stay.
  - FULL: `out` → BUSY, main ← skid. Otherwise stay. `in` cannot occur because `d_ready_o`=0.
- `d_valid_i` and `d_data_i` are ignored when `d_ready_o`=0.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Holding rule: while `s_valid_o`=1 and `s_ready_i`=0, `s_valid_o` and `s_data_o` hold constant.
- The block never withdraws `s_valid_o` without an `out`.

## Timing
- Reset values, applied on any edge with `rst`=1:
  - state = EMPTY.
  - `s_valid_o`=0, `s_data_o`=0, skid=0.
  - `d_ready_o`=0.
  - `xfer_cnt_o`=0.
- `d_ready_o` rises on the first edge with `rst`=0.
- Reset mid-operation: all stored words are discarded on that edge. No `out` is counted on a reset edge.
- Latency: a word accepted at edge N is on `s_data_o` with `s_valid_o`=1 after edge N, available for `out` in cycle N+1.
- Backpressure response:
  - `s_ready_i` falling with BUSY and `in` → FULL; `d_ready_o`=0 after that edge.
  - One cycle of `s_ready_i`=1 in FULL → BUSY; `d_ready_o`=1 after that edge.
- Full throughput: with `d_valid_i`=`s_ready_i`=1 continuously, the block stays in BUSY with one transfer per cycle on each side.

## Configuration
- `HS_SKID_CNT_EN` defined:
  - `xfer_cnt_o` exists: a 16-bit counter incremented on each `out`.
  - Reset value 0; wraps 0xFFFF → 0x0000.
  - Simultaneous `out` and `rst`: reset wins.
- `HS_SKID_CNT_EN` undefined:
  - port and counter are absent.
  - all other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `d_valid_i`=1 and `d_data_i`=0xAA → `s_valid_o`=0, `d_ready_o`=0, `s_data_o`=0x00. After release, `d_ready_o`=1 one edge later.
- Streaming: send 0x01..0x10 with `s_ready_i`=1 continuously → `s_data_o` = 0x01..0x10 in order, one per cycle, first word one cycle after acceptance. `xfer_cnt_o`=16.
- Skid: in BUSY holding 0x11, drop `s_ready_i` while 0x22 is accepted → FULL, `d_ready_o`=0, `s_data_o`=0x11 held. Raise `s_ready_i` → outputs 0x11 then 0x22; `d_ready_o`=1 after the first `out`.
- Random stall: random `d_valid_i` and `s_ready_i` at 50% each for 1000 cycles → scoreboard matches in order. No change of `s_data_o` while stalled. No combinational `s_ready_i`→`d_ready_o` path (check `d_ready_o` only changes at edges).
- Reset mid-FULL: assert `rst` with 0x33/0x44 stored → next cycle EMPTY, `s_valid_o`=0. 0x33 and 0x44 never appear.
- Wrap (macro on): preload the counter by 65535 transfers, then 1 more → `xfer_cnt_o`=0x0000. Macro off: the build has no `xfer_cnt_o` port.
